// File: rtl/microcode_sequencer_if.sv
// Loader, instruction-register and datapath-facing signals of the microcode sequencer.
// master = loader/IR/datapath side, slave = sequencer.
interface microcode_sequencer_if #(
    parameter int CTRL_W   = 23,
    parameter int UADDR_W  = 6,
    parameter int OPCODE_W = 8
);
    logic                       start;
    logic [OPCODE_W-1:0]        opcode;
    logic                       mem_ready;
    logic                       uc_we;
    logic [UADDR_W-1:0]         uc_addr;
    logic [CTRL_W+UADDR_W+2:0]  uc_wdata;
    logic                       dt_we;
    logic [OPCODE_W-1:0]        dt_opcode;
    logic [UADDR_W-1:0]         dt_uaddr;
    logic [CTRL_W-1:0]          control_out;
    logic [UADDR_W-1:0]         upc;
    logic                       busy;
    logic                       halted;
    logic                       illegal_op;

    modport master (
        output start, opcode, mem_ready, uc_we, uc_addr, uc_wdata,
               dt_we, dt_opcode, dt_uaddr,
        input  control_out, upc, busy, halted, illegal_op
    );

    modport slave (
        input  start, opcode, mem_ready, uc_we, uc_addr, uc_wdata,
               dt_we, dt_opcode, dt_uaddr,
        output control_out, upc, busy, halted, illegal_op
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: loadable store + opcode dispatch table driving a registered control word.
// Control word appears one cycle after upc addresses it; mem_ready low stalls wait-flagged words.
module microcode_sequencer #(
    parameter int CTRL_W   = 23,
    parameter int UADDR_W  = 6,
    parameter int OPCODE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    microcode_sequencer_if.slave  bus
);
    localparam int WORD_W = CTRL_W + UADDR_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    logic [WORD_W-1:0]     store [2**UADDR_W];
    logic [UADDR_W-1:0]    dtab  [2**OPCODE_W];
    logic [2**OPCODE_W-1:0] dval;

    state_t              state, state_next;
    logic [UADDR_W-1:0]  upc_reg, upc_next;
    logic [CTRL_W-1:0]   ctrl_reg, ctrl_next;
    logic                ill_reg, ill_next;
    logic                busy_reg, halted_reg;

    logic [WORD_W-1:0]   word;
    logic                w_wait;
    logic [1:0]          w_seq;
    logic [UADDR_W-1:0]  w_next;
    logic [CTRL_W-1:0]   w_ctrl;
    logic                load_ok;

    assign load_ok = (state != S_RUN);
    assign word    = store[upc_reg];
    assign w_wait  = word[WORD_W-1];
    assign w_seq   = word[WORD_W-2 -: 2];
    assign w_next  = word[CTRL_W +: UADDR_W];
    assign w_ctrl  = word[CTRL_W-1:0];

    // Tables are not reset; only the dispatch valid bits are.
    always_ff @(posedge clock) begin
        if (bus.uc_we && load_ok)
            store[bus.uc_addr] <= bus.uc_wdata;
        if (bus.dt_we && load_ok)
            dtab[bus.dt_opcode] <= bus.dt_uaddr;
    end

    always_comb begin
        state_next = state;
        upc_next   = upc_reg;
        ctrl_next  = '0;
        ill_next   = ill_reg;
        case (state)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_next = S_RUN;
                    upc_next   = '0;
                    ill_next   = 1'b0;
                end
            end
            S_RUN: begin
                ctrl_next = w_ctrl;
                // A wait stall outranks every sequencing action, including HALT and DISPATCH.
                if (!(w_wait && !bus.mem_ready)) begin
                    case (w_seq)
                        2'd0: upc_next = upc_reg + UADDR_W'(1);
                        2'd1: upc_next = w_next;
                        2'd2: begin
                            if (dval[bus.opcode]) begin
                                upc_next = dtab[bus.opcode];
                            end else begin
                                ctrl_next  = '0;
                                state_next = S_HALTED;
                                ill_next   = 1'b1;
                            end
                        end
                        default: state_next = S_HALTED;
                    endcase
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            upc_reg    <= '0;
            ctrl_reg   <= '0;
            ill_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b0;
            dval       <= '0;
        end else begin
            state      <= state_next;
            upc_reg    <= upc_next;
            ctrl_reg   <= ctrl_next;
            ill_reg    <= ill_next;
            busy_reg   <= (state_next == S_RUN);
            halted_reg <= (state_next == S_HALTED);
            if (bus.dt_we && load_ok)
                dval[bus.dt_opcode] <= 1'b1;
        end
    end

    assign bus.control_out = ctrl_reg;
    assign bus.upc         = upc_reg;
    assign bus.busy        = busy_reg;
    assign bus.halted      = halted_reg;
    assign bus.illegal_op  = ill_reg;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed programs plus random programs against a program-level model.
module tb_microcode_sequencer;
    localparam int CTRL_W   = 23;
    localparam int UADDR_W  = 6;
    localparam int OPCODE_W = 8;
    localparam int WORD_W   = CTRL_W + UADDR_W + 3;
    localparam int DEPTH    = 64;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    typedef struct { bit wt; int seq; int nxt; int ctrl; } uword_t;
    typedef struct {
        int tag; string nm; int ctrl; int upc;
        bit busy; bit halted; bit ill; bit upc_care;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    microcode_sequencer_if #(.CTRL_W(CTRL_W), .UADDR_W(UADDR_W), .OPCODE_W(OPCODE_W)) bus();

    microcode_sequencer #(.CTRL_W(CTRL_W), .UADDR_W(UADDR_W), .OPCODE_W(OPCODE_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    // Reference model: the program as words in an array, dispatch table as a map (key present = valid).
    uword_t m_store[DEPTH];
    int     m_dt[int];
    int     m_mode = M_IDLE;
    int     m_upc  = 0;
    int     m_ctrl = 0;
    bit     m_ill  = 1'b0;
    uword_t drv_word;

    function automatic uword_t mk(bit wt, int seq, int nxt, int ctrl);
        uword_t w;
        w.wt = wt; w.seq = seq; w.nxt = nxt; w.ctrl = ctrl;
        return w;
    endfunction

    function automatic uword_t rand_word();
        int s;
        s = int'($urandom_range(0, 9));
        return mk(($urandom_range(0, 3) == 0), (s < 4) ? 0 : (s < 6) ? 1 : (s < 8) ? 2 : 3,
                  int'($urandom_range(0, DEPTH-1)), int'($urandom % (1 << CTRL_W)));
    endfunction

    function automatic logic [WORD_W-1:0] pack(uword_t w);
        return {w.wt, 2'(w.seq), UADDR_W'(w.nxt), CTRL_W'(w.ctrl)};
    endfunction

    task automatic model_step();
        uword_t w;
        int op;
        if (reset) begin
            m_mode = M_IDLE; m_upc = 0; m_ctrl = 0; m_ill = 1'b0;
            m_dt.delete();
            return;
        end
        if (m_mode != M_RUN) begin
            if (bus.uc_we) m_store[int'(bus.uc_addr)] = drv_word;
            if (bus.dt_we) m_dt[int'(bus.dt_opcode)] = int'(bus.dt_uaddr);
            m_ctrl = 0;
            if (bus.start) begin
                m_mode = M_RUN; m_upc = 0; m_ill = 1'b0;
            end
        end else begin
            w = m_store[m_upc];
            m_ctrl = w.ctrl;
            if (!(w.wt && !bus.mem_ready)) begin
                op = int'(bus.opcode);
                if (w.seq == 0) m_upc = (m_upc + 1) % DEPTH;
                else if (w.seq == 1) m_upc = w.nxt;
                else if (w.seq == 2) begin
                    if (m_dt.exists(op)) m_upc = m_dt[op];
                    else begin m_ctrl = 0; m_mode = M_HALT; m_ill = 1'b1; end
                end else m_mode = M_HALT;
            end
        end
    endtask

    // Inputs are already driven; predict the outputs after the coming edge and advance one cycle.
    task automatic tick(string nm);
        exp_t e;
        model_step();
        e.tag = edge_cnt + 1; e.nm = nm;
        e.ctrl = m_ctrl; e.upc = m_upc;
        e.busy = (m_mode == M_RUN); e.halted = (m_mode == M_HALT); e.ill = m_ill;
        e.upc_care = (m_mode != M_HALT);
        exp_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic load(int addr, uword_t w, string nm);
        drv_word = w;
        bus.uc_we = 1'b1; bus.uc_addr = UADDR_W'(addr); bus.uc_wdata = pack(w);
        tick(nm);
        bus.uc_we = 1'b0;
    endtask

    task automatic dt_load(int op, int ua, string nm);
        bus.dt_we = 1'b1; bus.dt_opcode = OPCODE_W'(op); bus.dt_uaddr = UADDR_W'(ua);
        tick(nm);
        bus.dt_we = 1'b0;
    endtask

    task automatic pulse_start(string nm);
        bus.start = 1'b1;
        tick(nm);
        bus.start = 1'b0;
    endtask

    task automatic run(int n, string nm);
        repeat (n) tick(nm);
    endtask

    // Monitor: compares every prediction once its edge has happened.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.control_out !== CTRL_W'(e.ctrl) || bus.busy !== e.busy ||
                    bus.halted !== e.halted || bus.illegal_op !== e.ill ||
                    (e.upc_care && bus.upc !== UADDR_W'(e.upc))) begin
                    n_err++;
                    $display("FAIL %s edge %0d: got ctrl=%0d upc=%0d busy=%b halted=%b ill=%b; expected ctrl=%0d upc=%0d%s busy=%b halted=%b ill=%b",
                             e.nm, e.tag, bus.control_out, bus.upc, bus.busy, bus.halted, bus.illegal_op,
                             e.ctrl, e.upc, e.upc_care ? "" : "(any)", e.busy, e.halted, e.ill);
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b1;
        bus.uc_we = 1'b0; bus.uc_addr = '0; bus.uc_wdata = '0;
        bus.dt_we = 1'b0; bus.dt_opcode = '0; bus.dt_uaddr = '0;
        drv_word = mk(0, 0, 0, 0);
        reset = 1'b1;
        run(2, "reset_state");
        reset = 1'b0;
        run(1, "idle_hold");

        // Straight-line program ending in HALT.
        load(0, mk(0, 0, 0, 33856), "load");
        load(1, mk(0, 0, 0, 2098178), "load");
        load(2, mk(0, 3, 0, 1), "load");
        pulse_start("seq_start");
        run(5, "seq_next_halt");

        // Opcode dispatch to a HALT word.
        dt_load(8'h07, 20, "dt_load");
        load(0, mk(0, 2, 0, 17), "load");
        load(20, mk(0, 3, 0, 4194564), "load");
        bus.opcode = 8'h07;
        pulse_start("dispatch_start");
        run(3, "dispatch_valid");

        // Unmapped opcode halts with illegal_op; the next start clears it.
        bus.opcode = 8'h09;
        pulse_start("illegal_start");
        run(3, "dispatch_illegal");
        bus.opcode = 8'h07;
        pulse_start("illegal_clear");
        run(3, "after_clear");

        // Reset mid-run invalidates the dispatch table.
        load(0, mk(0, 1, 0, 123), "load");
        pulse_start("loop_start");
        run(3, "loop_run");
        reset = 1'b1;
        run(1, "reset_midrun");
        reset = 1'b0;
        run(1, "idle_after_reset");
        load(0, mk(0, 2, 0, 55), "load");
        bus.opcode = 8'h07;
        pulse_start("stale_dt_start");
        run(3, "stale_dt_illegal");

        // Wait-flagged word stalls while mem_ready is low.
        load(0, mk(1, 0, 0, 2099200), "load");
        load(1, mk(0, 3, 0, 3), "load");
        bus.mem_ready = 1'b0;
        pulse_start("wait_start");
        run(3, "wait_stall");
        bus.mem_ready = 1'b1;
        run(3, "wait_release");

        // upc wraps 63 -> 0; a store write during RUN must be ignored.
        dt_load(3, 63, "dt_load");
        load(63, mk(0, 0, 0, 5), "load");
        load(0, mk(0, 2, 0, 10), "load");
        bus.opcode = 8'd3;
        pulse_start("wrap_start");
        run(3, "wrap_run");
        drv_word = mk(0, 3, 0, 77);
        bus.uc_we = 1'b1; bus.uc_addr = '0; bus.uc_wdata = pack(drv_word);
        tick("uc_we_in_run");
        bus.uc_we = 1'b0;
        run(2, "wrap_run2");
        bus.opcode = 8'd9;
        run(4, "wrap_halt");
        bus.opcode = 8'd3;
        pulse_start("readback_start");
        run(3, "readback");

        // Random programs.
        for (int r = 0; r < 6; r++) begin
            reset = 1'b1;
            tick("rnd_reset");
            reset = 1'b0;
            for (int a = 0; a < DEPTH; a++) load(a, rand_word(), "rnd_load");
            for (int k = 0; k < 8; k++)
                dt_load(int'($urandom_range(0, 15)), int'($urandom_range(0, DEPTH-1)), "rnd_dt");
            bus.opcode = OPCODE_W'($urandom_range(0, 15));
            pulse_start("rnd_start");
            for (int c = 0; c < 150; c++) begin
                bus.mem_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) bus.opcode = OPCODE_W'($urandom_range(0, 15));
                bus.start = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    drv_word = rand_word();
                    bus.uc_we = 1'b1; bus.uc_addr = UADDR_W'($urandom_range(0, DEPTH-1));
                    bus.uc_wdata = pack(drv_word);
                end
                if ($urandom_range(0, 15) == 0) begin
                    bus.dt_we = 1'b1; bus.dt_opcode = OPCODE_W'($urandom_range(0, 15));
                    bus.dt_uaddr = UADDR_W'($urandom_range(0, DEPTH-1));
                end
                tick("rnd_run");
                bus.start = 1'b0; bus.uc_we = 1'b0; bus.dt_we = 1'b0;
            end
        end
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        run(2, "final_reset");

        repeat (5) begin
            if (exp_q.size() > 0) @(negedge clock);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions never compared, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
